multiplexor_display_7s: RTL and testbench



---
 rtl/multiplexor_display_7s.sv | 119 +++++++++++
 tb/tb_multiplexor_display_7s.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/multiplexor_display_7s.sv
// multiplexor_display_7s: time-multiplexes the adder's three 7-segment
// patterns and its carry onto one 4-digit common-segment display. Before
// each digit lights, every digit is held dark for a blanking interval to
// suppress ghosting. All pins come straight from registers.
module multiplexor_display_7s #(
  parameter int CICLOS_POR_DIGITO = 50000,
  parameter int CICLOS_BLANK      = 1000,
  parameter int ACTIVO_BAJO       = 1
) (
  input  logic       Clk,
  input  logic       Rst_n,
  input  logic       Habilitar,
  input  logic [6:0] X_Display,
  input  logic [6:0] Y_Display,
  input  logic [6:0] Resultado_Display,
  input  logic       CarriSalida,
  output logic [6:0] Segmentos,
  output logic [3:0] Anodos,
  output logic       FinTrama
);

  localparam int CMAX = (CICLOS_POR_DIGITO > CICLOS_BLANK) ? CICLOS_POR_DIGITO : CICLOS_BLANK;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
  localparam logic [CW-1:0] FIN_BLANK = CW'(CICLOS_BLANK - 1);
  localparam logic [CW-1:0] FIN_SHOW  = CW'(CICLOS_POR_DIGITO - 1);

  typedef enum logic {BLANK, SHOW} state_t;

  state_t          state, state_next;
  logic [CW-1:0]   cnt, cnt_next;
  logic [1:0]      idx, idx_next;
  // Low only during the first edge after reset release. That edge arms the
  // scanner, so the first digit lights CICLOS_BLANK edges after release.
  logic            armed;
  // Logical (active-high) copies of the output registers.
  logic [3:0]      an_q, an_next;
  logic [6:0]      seg_q, seg_next;
  logic            fin_q, fin_next;
  logic [6:0]      patron;

  // Pattern for the digit currently indexed. Digit 3 shows "1" or blank.
  always_comb begin
    case (idx)
      2'd0:    patron = Resultado_Display;
      2'd1:    patron = Y_Display;
      2'd2:    patron = X_Display;
      default: patron = CarriSalida ? 7'b0000110 : 7'b0000000;
    endcase
  end

  // Next state and next output values. Disable overrides terminal count.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    idx_next   = idx;
    an_next    = an_q;
    seg_next   = seg_q;
    fin_next   = 1'b0;
    if (!armed || !Habilitar) begin
      state_next = BLANK;
      cnt_next   = '0;
      an_next    = '0;
      seg_next   = '0;
    end else begin
      case (state)
        BLANK: begin
          an_next  = '0;
          seg_next = '0;
          if (cnt == FIN_BLANK) begin
            state_next = SHOW;
            cnt_next   = '0;
            an_next    = 4'(4'b0001 << idx);
            seg_next   = patron;
          end else begin
            cnt_next = cnt + 1'b1;
          end
        end
        SHOW: begin
          if (cnt == FIN_SHOW) begin
            state_next = BLANK;
            cnt_next   = '0;
            idx_next   = idx + 2'd1;
            an_next    = '0;
            seg_next   = '0;
            fin_next   = (idx == 2'd3);
          end else begin
            cnt_next = cnt + 1'b1;
          end
        end
      endcase
    end
  end

  // State, counters and output registers with synchronous reset.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state <= BLANK;
      cnt   <= '0;
      idx   <= '0;
      armed <= 1'b0;
      an_q  <= '0;
      seg_q <= '0;
      fin_q <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      idx   <= idx_next;
      armed <= 1'b1;
      an_q  <= an_next;
      seg_q <= seg_next;
      fin_q <= fin_next;
    end
  end

  assign Anodos    = (ACTIVO_BAJO != 0) ? ~an_q  : an_q;
  assign Segmentos = (ACTIVO_BAJO != 0) ? ~seg_q : seg_q;
  assign FinTrama  = fin_q;

endmodule

// File: tb/tb_multiplexor_display_7s.sv
// Bench for multiplexor_display_7s: one active-low and one active-high
// instance share the same stimulus; directed scenarios plus a randomized run
// checked against a slot-arithmetic reference model.
module tb_multiplexor_display_7s;
  localparam int B = 2;
  localparam int P = 4;
  localparam int L = B + P;

  logic       Clk = 1'b0;
  logic       Rst_n = 1'b0;
  logic       Habilitar = 1'b1;
  logic [6:0] X_Display = '0;
  logic [6:0] Y_Display = '0;
  logic [6:0] Resultado_Display = '0;
  logic       CarriSalida = 1'b0;
  logic [6:0] seg_lo, seg_hi;
  logic [3:0] an_lo, an_hi;
  logic       fin_lo, fin_hi;
  int tests = 0;
  int fails = 0;

  always #5 Clk = ~Clk;

  multiplexor_display_7s #(.CICLOS_POR_DIGITO(P), .CICLOS_BLANK(B), .ACTIVO_BAJO(1)) u_lo (
    .Clk(Clk), .Rst_n(Rst_n), .Habilitar(Habilitar), .X_Display(X_Display),
    .Y_Display(Y_Display), .Resultado_Display(Resultado_Display),
    .CarriSalida(CarriSalida), .Segmentos(seg_lo), .Anodos(an_lo), .FinTrama(fin_lo));

  multiplexor_display_7s #(.CICLOS_POR_DIGITO(P), .CICLOS_BLANK(B), .ACTIVO_BAJO(0)) u_hi (
    .Clk(Clk), .Rst_n(Rst_n), .Habilitar(Habilitar), .X_Display(X_Display),
    .Y_Display(Y_Display), .Resultado_Display(Resultado_Display),
    .CarriSalida(CarriSalida), .Segmentos(seg_hi), .Anodos(an_hi), .FinTrama(fin_hi));

  function automatic logic [6:0] pattern_of(int d);
    case (d)
      0:       return Resultado_Display;
      1:       return Y_Display;
      2:       return X_Display;
      default: return CarriSalida ? 7'b0000110 : 7'b0000000;
    endcase
  endfunction

  // Reference model: position n since the last (re)start of scanning; the
  // digit is (base + n/L) mod 4 and it is lit once n mod L reaches B.
  int         m_n = 0, m_base = 0;
  bit         m_armed = 0;
  logic [3:0] m_an = '0;
  logic [6:0] m_seg = '0;
  logic       m_fin = 1'b0;
  always @(posedge Clk) begin
    int d, o;
    if (!Rst_n) begin
      m_n = 0; m_base = 0; m_armed = 0; m_an = '0; m_seg = '0; m_fin = 1'b0;
    end else if (!m_armed) begin
      m_armed = 1; m_an = '0; m_seg = '0; m_fin = 1'b0;
    end else if (!Habilitar) begin
      m_base = (m_base + m_n / L) % 4; m_n = 0;
      m_an = '0; m_seg = '0; m_fin = 1'b0;
    end else begin
      m_n++;
      d = (m_base + m_n / L) % 4;
      o = m_n % L;
      m_fin = (o == 0) && (d == 0);
      if (o < B) begin
        m_an = '0; m_seg = '0;
      end else if (o == B) begin
        m_an = 4'(1 << d); m_seg = pattern_of(d);
      end
    end
  end

  // Holds reset for one edge; the next posedge is "edge 0" after release.
  task automatic reset_dut();
    Rst_n = 1'b0;
    @(negedge Clk);
    Rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic lit;
    Habilitar = 1'b1;
    Resultado_Display = 7'b0111111;
    Rst_n = 1'b0;
    @(negedge Clk);
    tests++;
    if (an_lo !== 4'b1111 || seg_lo !== 7'b1111111 || fin_lo !== 1'b0) begin
      fails++; $display("FAIL reset_state: got an=%b seg=%b fin=%b exp an=1111 seg=1111111 fin=0", an_lo, seg_lo, fin_lo);
    end
    tests++;
    if (an_hi !== 4'b0000 || seg_hi !== 7'b0000000) begin
      fails++; $display("FAIL reset_state_hi: got an=%b seg=%b exp 0000 0000000", an_hi, seg_hi);
    end
    Rst_n = 1'b1;
    for (int k = 0; k <= 6; k++) begin
      @(negedge Clk);
      lit = (k >= 2 && k <= 5);
      tests++;
      if (an_lo !== (lit ? 4'b1110 : 4'b1111) || seg_lo !== (lit ? 7'b1000000 : 7'b1111111)) begin
        fails++; $display("FAIL first_digit edge %0d: got an=%b seg=%b lit_exp=%0b", k, an_lo, seg_lo, lit);
      end
    end
  endtask

  task automatic test_full_scan();
    logic [3:0] an_tbl [4];
    logic [6:0] pat [4];
    logic [3:0] ea;
    logic [6:0] es;
    int d, o;
    an_tbl = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    X_Display = 7'b0000110; Y_Display = 7'b1011011;
    Resultado_Display = 7'b1001111; CarriSalida = 1'b1;
    pat = '{7'b1001111, 7'b1011011, 7'b0000110, 7'b0000110};
    reset_dut();
    for (int k = 0; k < 50; k++) begin
      @(negedge Clk);
      d = (k / L) % 4; o = k % L;
      ea = (o >= B) ? an_tbl[d] : 4'b1111;
      es = (o >= B) ? ~pat[d] : 7'b1111111;
      tests++;
      if (an_lo !== ea || seg_lo !== es) begin
        fails++; $display("FAIL full_scan edge %0d: got an=%b seg=%b exp an=%b seg=%b", k, an_lo, seg_lo, ea, es);
      end
      tests++;
      if (an_hi !== ~ea || seg_hi !== ~es) begin
        fails++; $display("FAIL full_scan_hi edge %0d: got an=%b seg=%b exp an=%b seg=%b", k, an_hi, seg_hi, ~ea, ~es);
      end
      tests++;
      if (fin_lo !== (k == 24 || k == 48) || fin_hi !== fin_lo) begin
        fails++; $display("FAIL fin_trama edge %0d: got %b/%b exp %0b", k, fin_lo, fin_hi, (k == 24 || k == 48));
      end
    end
  endtask

  task automatic test_carry_blank();
    CarriSalida = 1'b0;
    reset_dut();
    for (int k = 0; k < 24; k++) begin
      @(negedge Clk);
      if (k >= 20) begin
        tests++;
        if (an_lo !== 4'b0111 || seg_lo !== 7'b1111111) begin
          fails++; $display("FAIL carry_blank edge %0d: got an=%b seg=%b exp an=0111 seg=1111111", k, an_lo, seg_lo);
        end
      end
    end
  endtask

  task automatic test_capture();
    Resultado_Display = 7'b1101101;
    reset_dut();
    for (int k = 0; k < 30; k++) begin
      @(negedge Clk);
      if (k >= 2 && k <= 5) begin
        tests++;
        if (an_lo !== 4'b1110 || seg_lo !== ~7'b1101101) begin
          fails++; $display("FAIL capture_hold edge %0d: got an=%b seg=%b exp an=1110 seg=%b", k, an_lo, seg_lo, ~7'b1101101);
        end
      end
      if (k >= 26) begin
        tests++;
        if (an_lo !== 4'b1110 || seg_lo !== ~7'b1111101) begin
          fails++; $display("FAIL capture_new edge %0d: got an=%b seg=%b exp an=1110 seg=%b", k, an_lo, seg_lo, ~7'b1111101);
        end
      end
      if (k == 3) Resultado_Display = 7'b1111101;
    end
  endtask

  task automatic test_enable();
    logic lit;
    X_Display = 7'b1110111;
    reset_dut();
    for (int k = 0; k <= 22; k++) begin
      @(negedge Clk);
      if (k >= 14) begin
        lit = (k == 14) || (k >= 19);
        tests++;
        if (an_lo !== (lit ? 4'b1011 : 4'b1111) || seg_lo !== (lit ? ~7'b1110111 : 7'b1111111) || fin_lo !== 1'b0) begin
          fails++; $display("FAIL enable edge %0d: got an=%b seg=%b fin=%b lit_exp=%0b", k, an_lo, seg_lo, fin_lo, lit);
        end
      end
      if (k == 14) Habilitar = 1'b0;
      if (k == 17) Habilitar = 1'b1;
    end
  endtask

  task automatic test_mid_reset();
    Resultado_Display = 7'b0111001;
    reset_dut();
    for (int k = 0; k <= 13; k++) begin
      @(negedge Clk);
      if (k == 8) begin
        tests++;
        if (an_lo !== 4'b1101) begin
          fails++; $display("FAIL mid_reset_pre: got an=%b exp 1101", an_lo);
        end
        Rst_n = 1'b0;
      end else if (k == 9) begin
        tests++;
        if (an_lo !== 4'b1111 || seg_lo !== 7'b1111111 || fin_lo !== 1'b0) begin
          fails++; $display("FAIL mid_reset_vals: got an=%b seg=%b fin=%b exp 1111 1111111 0", an_lo, seg_lo, fin_lo);
        end
        Rst_n = 1'b1;
      end else if (k >= 10) begin
        tests++;
        if (an_lo !== ((k >= 12) ? 4'b1110 : 4'b1111) || seg_lo !== ((k >= 12) ? ~7'b0111001 : 7'b1111111)) begin
          fails++; $display("FAIL mid_reset_restart edge %0d: got an=%b seg=%b", k, an_lo, seg_lo);
        end
      end
    end
  endtask

  task automatic test_random();
    reset_dut();
    for (int i = 0; i < 900; i++) begin
      @(negedge Clk);
      tests++;
      if (an_lo !== ~m_an || seg_lo !== ~m_seg || fin_lo !== m_fin) begin
        fails++; $display("FAIL random_lo cyc %0d: got an=%b seg=%b fin=%b exp an=%b seg=%b fin=%b", i, an_lo, seg_lo, fin_lo, ~m_an, ~m_seg, m_fin);
      end
      tests++;
      if (an_hi !== m_an || seg_hi !== m_seg || fin_hi !== m_fin) begin
        fails++; $display("FAIL random_hi cyc %0d: got an=%b seg=%b fin=%b exp an=%b seg=%b fin=%b", i, an_hi, seg_hi, fin_hi, m_an, m_seg, m_fin);
      end
      tests++;
      if ($countones(an_hi) > 1) begin
        fails++; $display("FAIL onehot cyc %0d: got an=%b exp at most one bit", i, an_hi);
      end
      X_Display = 7'($urandom);
      Y_Display = 7'($urandom);
      Resultado_Display = 7'($urandom);
      CarriSalida = 1'($urandom);
      Habilitar = ($urandom_range(0, 39) != 0);
      Rst_n = ($urandom_range(0, 199) != 0);
    end
    Rst_n = 1'b1;
    Habilitar = 1'b1;
  endtask

  initial begin
    @(negedge Clk);
    test_reset();
    test_full_scan();
    test_carry_blank();
    test_capture();
    test_enable();
    test_mid_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
